// File: rtl/dadda_mul8_seq_pkg.sv
// Shared types and constants for the nibble-serial 8x8 multiplier controller.
package dadda_mul8_seq_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of nibble-pair passes through the 4x4 core.
    localparam int NPASS = 4;

    // Pass index.
    typedef logic [1:0] pass_t;

    // Left shift applied to each pass's partial product.
    localparam logic [3:0] SHIFT_P0 = 4'd0;
    localparam logic [3:0] SHIFT_P1 = 4'd4;
    localparam logic [3:0] SHIFT_P2 = 4'd4;
    localparam logic [3:0] SHIFT_P3 = 4'd8;

    // Shift amount for a given pass.
    function automatic logic [3:0] pass_shift(input pass_t pass);
        logic [3:0] sh;
        case (pass)
            2'd0:    sh = SHIFT_P0;
            2'd1:    sh = SHIFT_P1;
            2'd2:    sh = SHIFT_P2;
            2'd3:    sh = SHIFT_P3;
            default: sh = 4'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/dadda_multiplier.sv
// Combinational 4x4 unsigned Dadda multiplier: AND-array partial products,
// two Dadda reduction stages (heights 4 -> 3 -> 2) and a final carry-propagate add.
module dadda_multiplier (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] prod
);

    // Half adder, returns {carry, sum}.
    function automatic logic [1:0] ha(input logic i0, input logic i1);
        return {i0 & i1, i0 ^ i1};
    endfunction

    // Full adder, returns {carry, sum}.
    function automatic logic [1:0] fa(input logic i0, input logic i1, input logic i2);
        return {(i0 & i1) | (i0 & i2) | (i1 & i2), i0 ^ i1 ^ i2};
    endfunction

    logic [3:0] pp_s [4];   // pp_s[i][j] = y[i] & x[j], weight i+j
    logic [1:0] r1_s, r2_s, r3_s, r4_s, r5_s, r6_s;
    logic [7:0] row_x_s, row_y_s;

    // Partial products, reduction tree and final addition.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pp_s[i] = x & {4{y[i]}};
        end
        // Stage 1: bring the tallest columns (3 and 4) down to height 3.
        r1_s = ha(pp_s[0][3], pp_s[1][2]);                 // col 3
        r2_s = ha(pp_s[1][3], pp_s[2][2]);                 // col 4
        // Stage 2: bring every column down to height 2.
        r3_s = ha(pp_s[0][2], pp_s[1][1]);                 // col 2
        r4_s = fa(pp_s[2][1], pp_s[3][0], r1_s[0]);        // col 3
        r5_s = fa(pp_s[3][1], r2_s[0], r1_s[1]);           // col 4
        r6_s = fa(pp_s[2][3], pp_s[3][2], r2_s[1]);        // col 5
        // Two remaining rows feed the carry-propagate adder.
        row_x_s = {1'b0, pp_s[3][3], r6_s[0], r5_s[0], r4_s[0],
                   pp_s[2][0], pp_s[0][1], pp_s[0][0]};
        row_y_s = {1'b0, r6_s[1], r5_s[1], r4_s[1], r3_s[1],
                   r3_s[0], pp_s[1][0], 1'b0};
        prod    = row_x_s + row_y_s;
    end

endmodule

// File: rtl/dadda_mul8_seq.sv
// Iterative 8x8 unsigned multiplier: four nibble-pair passes through one
// 4x4 Dadda core, shift-accumulated into a 16-bit product.
module dadda_mul8_seq
    import dadda_mul8_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        busy
);

    state_e      state_r, state_nxt_s;
    logic [7:0]  a_r, b_r;
    pass_t       pass_r;
    logic [15:0] acc_r;
    logic        in_ready_r, out_valid_r, busy_r;

    logic        in_fire_s;
    logic [3:0]  core_x_s, core_y_s;
    logic [7:0]  core_p_s;
    logic [15:0] addend_s;

    assign in_fire_s = in_valid && in_ready_r;

    // Nibble select and shift for the current pass; operands come only from registers.
    always_comb begin
        core_x_s = pass_r[0] ? a_r[7:4] : a_r[3:0];
        core_y_s = pass_r[1] ? b_r[7:4] : b_r[3:0];
        addend_s = {8'd0, core_p_s} << pass_shift(pass_r);
    end

    dadda_multiplier u_core (
        .x    (core_x_s),
        .y    (core_y_s),
        .prod (core_p_s)
    );

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_fire_s) state_nxt_s = MUL;
                else           state_nxt_s = IDLE;
            end
            MUL: begin
                if (pass_r == pass_t'(NPASS - 1)) state_nxt_s = DONE;
                else                              state_nxt_s = MUL;
            end
            DONE: begin
                if (out_ready) state_nxt_s = IDLE;
                else           state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    // Operand capture, pass counter and accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r    <= 8'd0;
            b_r    <= 8'd0;
            pass_r <= 2'd0;
            acc_r  <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_fire_s) begin
                        a_r    <= a;
                        b_r    <= b;
                        pass_r <= 2'd0;
                        acc_r  <= 16'd0;
                    end
                end
                MUL: begin
                    acc_r  <= acc_r + addend_s;
                    pass_r <= pass_r + 2'd1;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign p         = acc_r;

endmodule

// File: tb/tb_dadda_mul8_seq.sv
// Directed and randomized self-checking bench for dadda_mul8_seq.
module tb_dadda_mul8_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;

    int total;
    int bad;

    dadda_mul8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from IDLE with exact latency checks.
    task automatic mul_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [15:0] exp, input string tag);
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        tick();                          // E0
        in_valid = 1'b0;
        a = 8'h00;
        b = 8'h00;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        tick(); tick(); tick();          // E1..E3
        check({tag, "_early"}, 32'(out_valid), 32'd0);
        tick();                          // E4
        check({tag, "_ov"}, 32'(out_valid), 32'd1);
        check({tag, "_ir"}, 32'(in_ready), 32'd0);
        check({tag, "_p"}, 32'(p), 32'(exp));
        out_ready = 1'b1;
        tick();                          // E5
        out_ready = 1'b0;
        check({tag, "_ovlo"}, 32'(out_valid), 32'd0);
        check({tag, "_hold"}, 32'(p), 32'(exp));
    endtask

    initial begin
        int stamp_q[$];
        int cyc;
        int n_in, n_out, gap, guard;
        logic [7:0]  ra, rb;
        logic        got_out;

        total = 0;
        bad = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 8'h00;
        b = 8'h00;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_ir", 32'(in_ready), 32'd1);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_p", 32'(p), 32'h0000);

        // Directed vectors.
        mul_op(8'h12, 8'h34, 16'h03A8, "v12x34");
        mul_op(8'hFF, 8'hFF, 16'hFE01, "vFFxFF");
        mul_op(8'hF0, 8'h0F, 16'h0E10, "vF0x0F");
        mul_op(8'hA5, 8'h00, 16'h0000, "vA5x00");
        check("idle_ir", 32'(in_ready), 32'd1);

        // Back-to-back stream: one result every 6 cycles.
        in_valid = 1'b1;
        a = 8'h11;
        b = 8'h11;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) begin
                stamp_q.push_back(i);
                check("b2b_p", 32'(p), 32'h0121);
            end
            check("b2b_excl", 32'(in_ready && out_valid), 32'd0);
        end
        in_valid = 1'b0;
        check("b2b_cnt", 32'(stamp_q.size()), 32'd3);
        if (stamp_q.size() >= 2)
            check("b2b_gap", 32'(stamp_q[1] - stamp_q[0]), 32'd6);
        // Drain whatever is still in flight.
        guard = 0;
        while (busy && guard < 20) begin
            tick();
            guard++;
        end
        out_ready = 1'b0;
        check("b2b_drain", 32'(in_ready), 32'd1);

        // Backpressure with a second request waiting.
        in_valid = 1'b1;
        a = 8'h12;
        b = 8'h34;
        tick();                          // E0
        a = 8'h02;
        b = 8'h03;
        tick(); tick(); tick(); tick();  // E1..E4, second request held
        for (int i = 0; i < 5; i++) begin
            check("bp_ov", 32'(out_valid), 32'd1);
            check("bp_ir", 32'(in_ready), 32'd0);
            check("bp_p", 32'(p), 32'h03A8);
            tick();
        end
        out_ready = 1'b1;
        tick();                          // handshake
        out_ready = 1'b0;
        check("bp_after_ir", 32'(in_ready), 32'd1);
        check("bp_after_p", 32'(p), 32'h03A8);
        tick();                          // second acceptance
        in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        check("bp_second_ov", 32'(out_valid), 32'd1);
        check("bp_second_p", 32'(p), 32'h0006);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset mid-MUL.
        in_valid = 1'b1;
        a = 8'h12;
        b = 8'h34;
        tick();                          // E0
        in_valid = 1'b0;
        tick(); tick();                  // E1, E2
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_ir", 32'(in_ready), 32'd1);
        check("mr_ov", 32'(out_valid), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_p", 32'(p), 32'h0000);
        got_out = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) got_out = 1'b1;
        end
        check("mr_stale", 32'(got_out), 32'd0);

        // Randomized operands with random valid/ready gaps.
        n_in = 0;
        n_out = 0;
        for (int k = 0; k < 400; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            in_valid = 1'b1;
            a = ra;
            b = rb;
            guard = 0;
            while (!in_ready && guard < 20) begin
                tick();
                guard++;
            end
            if (!in_ready) check("rnd_in_timeout", 32'd0, 32'd1);
            tick();
            n_in++;
            in_valid = 1'b0;
            guard = 0;
            got_out = 1'b0;
            while (!got_out && guard < 60) begin
                out_ready = ($urandom_range(0, 1) == 1);
                if (out_valid && out_ready) begin
                    check("rnd_p", 32'(p), 32'(16'(ra) * 16'(rb)));
                    n_out++;
                    got_out = 1'b1;
                end
                tick();
                guard++;
            end
            out_ready = 1'b0;
            if (!got_out) check("rnd_out_timeout", 32'd0, 32'd1);
        end
        check("rnd_counts", 32'(n_out), 32'(n_in));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
